// File: rtl/sram_pixel_fetch.sv
// Framebuffer reader: prefetches 3-3-3 pixels from an async SRAM into a small FIFO
// and hands them to the dvid encoder in step with the re-timed vga syncs.
module sram_pixel_fetch #(
   parameter int ADDR_W       = 18,
   parameter int DEPTH        = 8,
   parameter int READ_LATENCY = 2,
   parameter int BASE_ADDR    = 0,
   parameter int FRAME_WORDS  = 307200,
   parameter int SYNC_ACTIVE  = 0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              hsync_in,
   input  logic              vsync_in,
   input  logic              blank_in,
   input  logic              underflow_clr,
   input  logic [8:0]        sram_data,
   output logic [ADDR_W-1:0] sram_addr,
   output logic              sram_ce_n,
   output logic              sram_oe_n,
   output logic              hsync,
   output logic              vsync,
   output logic              blank,
   output logic [2:0]        red,
   output logic [2:0]        green,
   output logic [2:0]        blue,
   output logic              underflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int SUM_W = $clog2(DEPTH + READ_LATENCY + 1);
   localparam logic [ADDR_W-1:0] FIRST_ADDR    = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] LAST_ADDR     = ADDR_W'(BASE_ADDR + FRAME_WORDS - 1);
   localparam logic              SYNC_LVL      = 1'(SYNC_ACTIVE);
   localparam logic [8:0]        UNDERFLOW_RGB = 9'b111_000_000;
   localparam logic [SUM_W-1:0]  DEPTH_SUM     = SUM_W'(DEPTH);

   // Number of reads still travelling through the SRAM access pipeline.
   function automatic logic [SUM_W-1:0] tag_count(input logic [READ_LATENCY-1:0] tags);
      logic [SUM_W-1:0] n;
      n = {SUM_W{1'b0}};
      for (int i = 0; i < READ_LATENCY; i++) begin
         n = n + SUM_W'(tags[i]);
      end
      return n;
   endfunction

   logic [ADDR_W-1:0]       next_addr_r;
   logic [READ_LATENCY-1:0] tag_r;
   logic [8:0]              mem_r [DEPTH];
   logic [PTR_W-1:0]        rd_ptr_r;
   logic [PTR_W-1:0]        wr_ptr_r;
   logic [CNT_W-1:0]        count_r;
   logic [8:0]              rgb_r;

   logic                    flush_s;
   logic                    empty_s;
   logic [SUM_W-1:0]        inflight_s;
   logic [SUM_W-1:0]        total_s;
   logic                    issue_s;
   logic                    capture_s;
   logic                    pop_s;
   logic [8:0]              head_s;

   // Per-edge decisions. The credit check counts the read being captured this
   // edge as still in flight and ignores any pop, so it can never overfill.
   always_comb begin
      flush_s    = (vsync_in == SYNC_LVL) && (vsync != SYNC_LVL);
      empty_s    = (count_r == {CNT_W{1'b0}});
      inflight_s = tag_count(tag_r);
      total_s    = SUM_W'(count_r) + inflight_s;
      issue_s    = !flush_s && (total_s < DEPTH_SUM);
      capture_s  = !flush_s && tag_r[READ_LATENCY-1];
      pop_s      = !flush_s && !blank_in && !empty_s;
      head_s     = mem_r[rd_ptr_r];
   end

   // SRAM address and strobes; the address walks the frame and wraps.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sram_addr   <= FIRST_ADDR;
         next_addr_r <= FIRST_ADDR;
         sram_ce_n   <= 1'b1;
         sram_oe_n   <= 1'b1;
      end else if (flush_s) begin
         sram_addr   <= FIRST_ADDR;
         next_addr_r <= FIRST_ADDR;
         sram_ce_n   <= 1'b1;
         sram_oe_n   <= 1'b1;
      end else if (issue_s) begin
         sram_addr   <= next_addr_r;
         next_addr_r <= (next_addr_r == LAST_ADDR) ? FIRST_ADDR : next_addr_r + ADDR_W'(1);
         sram_ce_n   <= 1'b0;
         sram_oe_n   <= 1'b0;
      end else begin
         sram_ce_n   <= 1'b1;
         sram_oe_n   <= 1'b1;
      end
   end

   // Read tags: a 1 reaching the last stage marks sram_data as valid to capture.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tag_r <= {READ_LATENCY{1'b0}};
      end else if (flush_s) begin
         tag_r <= {READ_LATENCY{1'b0}};
      end else begin
         tag_r[0] <= issue_s;
         for (int i = 1; i < READ_LATENCY; i++) begin
            tag_r[i] <= tag_r[i-1];
         end
      end
   end

   // FIFO storage, written at the tail on capture.
   always_ff @(posedge clk) begin
      if (capture_s) begin
         mem_r[wr_ptr_r] <= sram_data;
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr_r <= {PTR_W{1'b0}};
         wr_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else if (flush_s) begin
         rd_ptr_r <= {PTR_W{1'b0}};
         wr_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (capture_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({capture_s, pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Pixel and sync outputs, all one cycle behind the vga inputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hsync     <= ~SYNC_LVL;
         vsync     <= ~SYNC_LVL;
         blank     <= 1'b1;
         rgb_r     <= 9'd0;
         underflow <= 1'b0;
      end else begin
         hsync <= hsync_in;
         vsync <= vsync_in;
         blank <= blank_in;
         if (flush_s || blank_in) begin
            rgb_r <= 9'd0;
         end else if (empty_s) begin
            rgb_r <= UNDERFLOW_RGB;
         end else begin
            rgb_r <= head_s;
         end
         if (underflow_clr) begin
            underflow <= 1'b0;
         end else if (!flush_s && !blank_in && empty_s) begin
            underflow <= 1'b1;
         end else begin
            underflow <= underflow;
         end
      end
   end

   assign red   = rgb_r[8:6];
   assign green = rgb_r[5:3];
   assign blue  = rgb_r[2:0];

endmodule

// File: tb/tb_sram_pixel_fetch.sv
// Bench for sram_pixel_fetch: queue-based reference model of the fetch/FIFO/output
// rules, a fill table, directed corner sequences and a randomized run.
module tb_sram_pixel_fetch;

   localparam int   ADDR_W = 18;
   localparam int   DEPTH  = 8;
   localparam int   LAT    = 2;
   localparam int   BASE   = 3;
   localparam int   FW     = 45;
   localparam int   LAST   = BASE + FW - 1;
   localparam logic SYNC   = 1'b0;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              hsync_in, vsync_in, blank_in, underflow_clr;
   logic [8:0]        sram_data;
   logic [ADDR_W-1:0] sram_addr;
   logic              sram_ce_n, sram_oe_n, hsync, vsync, blank, underflow;
   logic [2:0]        red, green, blue;

   int total = 0;
   int bad   = 0;

   sram_pixel_fetch #(
      .ADDR_W(ADDR_W), .DEPTH(DEPTH), .READ_LATENCY(LAT),
      .BASE_ADDR(BASE), .FRAME_WORDS(FW), .SYNC_ACTIVE(0)
   ) dut (
      .clk(clk), .reset_n(reset_n), .hsync_in(hsync_in), .vsync_in(vsync_in),
      .blank_in(blank_in), .underflow_clr(underflow_clr), .sram_data(sram_data),
      .sram_addr(sram_addr), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
      .hsync(hsync), .vsync(vsync), .blank(blank),
      .red(red), .green(green), .blue(blue), .underflow(underflow)
   );

   always #5 clk = ~clk;

   // SRAM model: data = addr[8:0] two edges after issue, junk if not enabled.
   logic [8:0] sram_d;
   always @(posedge clk) sram_d <= sram_ce_n ? ~sram_addr[8:0] : sram_addr[8:0];
   assign sram_data = sram_d;

   // Reference model state
   typedef struct { int addr; int due; } rd_t;
   rd_t        infl[$];
   logic [8:0] fifo[$];
   int         cyc = 0;
   int         m_next;
   int         e_addr;
   logic       e_addr_chk, e_ce, e_hs, e_vs, e_blank, e_uf;
   logic [8:0] e_rgb;

   task automatic model_reset();
      infl.delete();
      fifo.delete();
      m_next = BASE; e_addr = BASE; e_addr_chk = 1'b1; e_ce = 1'b1;
      e_hs = ~SYNC; e_vs = ~SYNC; e_blank = 1'b1; e_rgb = 9'd0; e_uf = 1'b0;
   endtask

   task automatic model_edge(input logic b, input logic hs, input logic vs, input logic clr);
      logic flush, credit, set;
      rd_t  r;
      cyc++;
      set    = 1'b0;
      flush  = (vs == SYNC) && (e_vs != SYNC);
      credit = (fifo.size() + infl.size()) < DEPTH;
      if (flush) begin
         fifo.delete(); infl.delete();
         e_rgb = 9'd0; e_ce = 1'b1; e_addr = BASE; e_addr_chk = 1'b1; m_next = BASE;
      end else begin
         if (b) e_rgb = 9'd0;
         else if (fifo.size() > 0) e_rgb = fifo.pop_front();
         else begin e_rgb = 9'b111_000_000; set = 1'b1; end
         if (infl.size() > 0 && infl[0].due == cyc) begin
            r = infl.pop_front();
            fifo.push_back(9'(r.addr));
         end
         if (credit) begin
            e_addr = m_next; e_ce = 1'b0; e_addr_chk = 1'b1;
            infl.push_back('{addr: m_next, due: cyc + LAT});
            m_next = (m_next == LAST) ? BASE : m_next + 1;
         end else begin
            e_ce = 1'b1; e_addr_chk = 1'b0;
         end
      end
      if (clr) e_uf = 1'b0;
      else if (set) e_uf = 1'b1;
      e_hs = hs; e_vs = vs; e_blank = b;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
      end
   endtask

   task automatic check_all();
      check("ce_n", 32'(sram_ce_n), 32'(e_ce));
      check("oe_n", 32'(sram_oe_n), 32'(e_ce));
      check("hsync", 32'(hsync), 32'(e_hs));
      check("vsync", 32'(vsync), 32'(e_vs));
      check("blank", 32'(blank), 32'(e_blank));
      check("rgb", 32'({red, green, blue}), 32'(e_rgb));
      check("underflow", 32'(underflow), 32'(e_uf));
      if (e_addr_chk) check("addr", 32'(sram_addr), 32'(e_addr));
   endtask

   task automatic step(input logic b, input logic hs, input logic vs, input logic clr);
      @(negedge clk);
      blank_in = b; hsync_in = hs; vsync_in = vs; underflow_clr = clr;
      model_edge(b, hs, vs, clr);
      @(posedge clk);
      #1;
      check_all();
   endtask

   typedef struct {
      logic        b;
      logic        exp_ce_n;
      logic        chk_addr;
      int          exp_addr;
      logic [8:0]  exp_rgb;
   } vec_t;
   vec_t tv[16];

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, total=%0d", total);
      $fatal(1);
   end

   initial begin
      logic vs_r, saw_last, saw_wrap;

      // Fill and start-of-line table (sync active low, so vsync_in=1 is idle)
      for (int i = 0; i < 16; i++) begin
         tv[i].b        = (i < 10) ? 1'b1 : 1'b0;
         tv[i].exp_ce_n = (i < 8 || i > 10) ? 1'b0 : 1'b1;
         tv[i].chk_addr = (i < 8 || i > 10) ? 1'b1 : 1'b0;
         tv[i].exp_addr = (i < 8) ? BASE + i : BASE + 8 + (i - 11);
         tv[i].exp_rgb  = (i < 10) ? 9'd0 : 9'(BASE + i - 10);
      end

      reset_n = 1'b0; blank_in = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1; underflow_clr = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      #1 reset_n = 1'b1;

      // 1/2: fill from reset, then active pixels in order
      for (int i = 0; i < 16; i++) begin
         step(tv[i].b, 1'b1, 1'b1, 1'b0);
         check("tbl_ce_n", 32'(sram_ce_n), 32'(tv[i].exp_ce_n));
         if (tv[i].chk_addr) check("tbl_addr", 32'(sram_addr), 32'(tv[i].exp_addr));
         check("tbl_rgb", 32'({red, green, blue}), 32'(tv[i].exp_rgb));
         check("tbl_uf", 32'(underflow), 32'd0);
      end
      repeat (14) step(1'b0, 1'b0, 1'b1, 1'b0);
      check("run_no_underflow", 32'(underflow), 32'd0);

      // 3: flush, then active pixels from an empty FIFO
      step(1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < LAT; i++) begin
         step(1'b0, 1'b1, 1'b0, 1'b0);
         check("uf_rgb", 32'({red, green, blue}), 32'h1C0);
         check("uf_set", 32'(underflow), 32'd1);
      end
      repeat (6) step(1'b0, 1'b1, 1'b0, 1'b0);
      check("uf_sticky", 32'(underflow), 32'd1);
      step(1'b1, 1'b1, 1'b0, 1'b1);
      check("uf_clear", 32'(underflow), 32'd0);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b1);
      check("uf_clear_wins", 32'(underflow), 32'd0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b1);

      // 4: flush while reads are in flight during an active run
      repeat (12) step(1'b1, 1'b1, 1'b1, 1'b0);
      repeat (10) step(1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      check("flush_rgb", 32'({red, green, blue}), 32'd0);
      check("flush_ce_n", 32'(sram_ce_n), 32'd1);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      check("flush_next_ce", 32'(sram_ce_n), 32'd0);
      check("flush_next_addr", 32'(sram_addr), 32'(BASE));
      repeat (10) step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      check("flush_first_pixel", 32'({red, green, blue}), 32'(9'(BASE)));

      // 5: long active run across the frame wrap
      saw_last = 1'b0; saw_wrap = 1'b0;
      for (int i = 0; i < 70; i++) begin
         step(1'b0, 1'(i % 2), 1'b1, 1'b0);
         if (!sram_ce_n && sram_addr == ADDR_W'(LAST)) saw_last = 1'b1;
         else if (saw_last && !sram_ce_n && sram_addr == ADDR_W'(BASE)) saw_wrap = 1'b1;
      end
      check("wrap_seen", 32'(saw_wrap), 32'd1);

      // 6: asynchronous reset mid-line with reads in flight
      repeat (3) step(1'b0, 1'b1, 1'b1, 1'b0);
      reset_n = 1'b0;
      blank_in = 1'b1;
      #1;
      model_reset();
      check_all();
      repeat (2) begin
         @(posedge clk);
         #1;
         check_all();
      end
      #1 reset_n = 1'b1;
      step(1'b1, 1'b1, 1'b1, 1'b0);
      check("rst_first_addr", 32'(sram_addr), 32'(BASE));
      check("rst_first_ce", 32'(sram_ce_n), 32'd0);
      repeat (10) step(1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      check("rst_first_pixel", 32'({red, green, blue}), 32'(9'(BASE)));

      // Randomized run against the model
      vs_r = 1'b1;
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 39) == 0) vs_r = ~vs_r;
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), vs_r,
              ($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
